imem_word_fetch: RTL
====================

Name: imem_word_fetch

Overview:
- Instruction-fetch adapter between the pipelined core's fetch port (i_addr, ce, i_data) and a 256 x 8-bit synchronous-read instruction memory.
- Assembles little-endian 32-bit instructions from four byte reads.
- Holds the last fetched word in a tagged line buffer, so repeat fetches of the same address return with zero latency.
- Raises a stall to the core while a fill is in progress.

Parameters:
ADDR_W, 8, byte-address width of the instruction memory (depth 2^ADDR_W).
NOP_INS, 32'h00000013, word driven on core_ins when not valid (addi x0,x0,0).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
core_ce  in  1  core fetch enable
core_addr  in  32  fetch byte address; only [ADDR_W-1:0] used
flush  in  1  branch redirect; aborts fill, invalidates buffers
core_ins  out  32  instruction word to IF/ID register
core_valid  out  1  core_ins holds the word for core_addr this cycle
core_stall  out  1  core must hold PC and IF/ID contents
mem_en  out  1  byte-memory read enable
mem_addr  out  ADDR_W  byte-memory address
mem_rdata  in  8  byte-memory data, valid the cycle after mem_en

Behaviour:
- Reset (rst=1 at a clk edge):
  - State IDLE; all buffer valid bits 0; fill counter 0.
  - Outputs: mem_en=0, mem_addr=0, core_valid=0, core_stall=0, core_ins=NOP_INS.
  - Reset mid-fill discards the partial word.
- Hit (combinational): core_ce=1, buf_valid=1 and core_addr[ADDR_W-1:0]==buf_tag.
  - core_ins=buf_data, core_valid=1, core_stall=0 in the same cycle.
- Miss: core_ce=1 and no hit.
  - core_stall=1 combinationally.
  - core_valid=0 and core_ins=NOP_INS until the cycle in which the hit occurs.
- States: IDLE, ISSUE, DRAIN.
  - IDLE:
    - On a miss (and flush=0), latch fill_addr=core_addr[ADDR_W-1:0] and set k=0.
    - Go to ISSUE with mem_en=1 and mem_addr=fill_addr.
  - ISSUE, cycles k=0..3:
    - mem_en=1, mem_addr=(fill_addr+k) mod 2^ADDR_W; wrap 255 -> 0 is required.
    - In cycle k>=1, capture mem_rdata into byte k-1.
    - After k=3, go to DRAIN.
  - DRAIN, one cycle:
    - mem_en=0; capture byte 3 into bits [31:24] (byte 0 goes to [7:0]).
    - Write buf_data, buf_tag=fill_addr, buf_valid=1; return to IDLE.
- Miss-to-valid latency: stall asserted for exactly 5 cycles (the miss cycle plus 4 memory cycles). The hit appears in cycle 6 if core_addr is unchanged.
- core_addr changes mid-fill: the fill completes for the latched fill_addr (no abort), then the hit check repeats in IDLE.
- core_ce=0 mid-fill: the fill completes and buffers update. core_stall follows the miss rule, so it is 0 while ce=0.
- Flush at any state:
  - Next state IDLE; all buf_valid cleared; partial bytes discarded; mem_en=0 next cycle.
  - No new fill starts in the same cycle as flush.
  - Flush has lower priority than rst.
- Misaligned address (core_addr[1:0]!=0): legal; the four consecutive bytes from that address are fetched, with wrap.

Optional Feature:
IMEM_NEXTLINE_PREFETCH_EN:
- Defined:
  - A second line buffer holds (tag, data, valid).
  - In IDLE with no miss, no flush and the next-line slot not holding last_tag+4, fill (last_tag+4) mod 2^ADDR_W into it.
  - A demand miss arriving during a prefetch waits for the prefetch to finish; stall covers the total.
  - A hit in either buffer is a zero-latency hit. The demand slot is replaced on a demand fill; the prefetch slot is replaced only by a prefetch.
- Undefined: single buffer; FSM never leaves IDLE without a demand miss.

Decomposition:
- Package imem_fetch_pkg: NOP_INS, BYTES_PER_WORD=4, fetch state enum (IDLE, ISSUE, DRAIN).
- Sub-module imem_line_buf: tag/data/valid register with write port, clear input and combinational hit compare.
  - Instantiated once, or twice under IMEM_NEXTLINE_PREFETCH_EN.

Test Plan:
- Cold fetch:
  - Stimulus: rst pulse, then ce=1, addr=0x10, mem bytes 0x10..0x13 = 13,05,10,00.
  - Required: stall high 5 cycles, mem_addr 10,11,12,13, then core_ins=0x00100513 with valid=1 and stall=0.
- Repeat hit: hold addr=0x10 for 3 more cycles -> no mem_en, valid=1 every cycle.
- Wrap: addr=0xFE -> mem_addr sequence FE,FF,00,01; the word assembles from those bytes in order.
- Flush mid-fill: flush on the 2nd ISSUE cycle -> mem_en=0 next cycle, buf_valid=0; a re-request of the same address takes the full 5-cycle stall.
- Address change mid-fill: 0x20 -> 0x24 during the fill -> 0x20 completes, then 0x24 misses and fills; no corrupted word on core_ins.
- Reset mid-fill: rst in DRAIN -> all outputs at reset values next cycle; the prior address misses again.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// Shared constants and fetch FSM state type for the byte-memory instruction-fetch adapter.
package imem_fetch_pkg;

    localparam logic [31:0] NOP_INS        = 32'h0000_0013;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/imem_line_buf.sv
// One tagged instruction line: tag/data/valid registers, write port, clear and hit compare.
module imem_line_buf #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wtag_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] ltag_i,
    output logic              hit_o,
    output logic [31:0]       data_o,
    output logic [ADDR_W-1:0] tag_o,
    output logic              valid_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] tag_q;
    logic [31:0]       data_q;

    // Clear wins over a same-cycle write so an aborted fill never lands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (we_i) begin
            valid_q <= 1'b1;
            tag_q   <= wtag_i;
            data_q  <= wdata_i;
        end
    end

    assign hit_o   = valid_q && (tag_q == ltag_i);
    assign data_o  = data_q;
    assign tag_o   = tag_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/imem_word_fetch.sv
// Instruction-fetch adapter: builds little-endian words from a byte-wide synchronous memory
// behind a tagged line buffer. Define IMEM_NEXTLINE_PREFETCH_EN for a next-line prefetch slot.
module imem_word_fetch #(
    parameter int unsigned ADDR_W  = 8,
    parameter logic [31:0] NOP_INS = imem_fetch_pkg::NOP_INS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_ce_i,
    input  logic [31:0]       core_addr_i,
    input  logic              flush_i,
    output logic [31:0]       core_ins_o,
    output logic              core_valid_o,
    output logic              core_stall_o,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i
);
    import imem_fetch_pkg::*;

    localparam logic [1:0] KLast = 2'(BYTES_PER_WORD - 1);

    fetch_state_e      state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [23:0]       bytes_q, bytes_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              pf_fill_q, pf_fill_d;

    logic [ADDR_W-1:0] req_tag, next_addr, dem_tag, pf_target;
    logic [31:0]       drain_word, dem_data, pf_data;
    logic              dem_hit, dem_valid, pf_hit, pf_start, fwd_hit, miss, drain_we;

    logic unused_addr;
    assign unused_addr = ^core_addr_i[31:ADDR_W];

    assign req_tag    = core_addr_i[ADDR_W-1:0];
    assign next_addr  = fill_addr_q + ADDR_W'(k_q) + ADDR_W'(1);
    assign drain_word = {mem_rdata_i, bytes_q};
    assign drain_we   = (state_q == StDrain);
    // The final byte arrives during DRAIN; forwarding it makes the word usable that same cycle.
    assign fwd_hit    = drain_we && (req_tag == fill_addr_q);
    assign miss       = core_ce_i && !(dem_hit || pf_hit || fwd_hit);
    assign pf_target  = dem_tag + ADDR_W'(BYTES_PER_WORD);

    imem_line_buf #(
        .ADDR_W(ADDR_W)
    ) u_dem_buf (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (flush_i),
        .we_i   (drain_we && !pf_fill_q),
        .wtag_i (fill_addr_q),
        .wdata_i(drain_word),
        .ltag_i (req_tag),
        .hit_o  (dem_hit),
        .data_o (dem_data),
        .tag_o  (dem_tag),
        .valid_o(dem_valid)
    );

`ifdef IMEM_NEXTLINE_PREFETCH_EN
    logic [ADDR_W-1:0] pf_tag;
    logic              pf_valid;

    imem_line_buf #(
        .ADDR_W(ADDR_W)
    ) u_pf_buf (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (flush_i),
        .we_i   (drain_we && pf_fill_q),
        .wtag_i (fill_addr_q),
        .wdata_i(drain_word),
        .ltag_i (req_tag),
        .hit_o  (pf_hit),
        .data_o (pf_data),
        .tag_o  (pf_tag),
        .valid_o(pf_valid)
    );

    assign pf_start = dem_valid && !(pf_valid && (pf_tag == pf_target));
`else
    logic unused_dem_valid;
    assign unused_dem_valid = dem_valid;
    assign pf_hit           = 1'b0;
    assign pf_data          = NOP_INS;
    assign pf_start         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        fill_addr_d = fill_addr_q;
        bytes_d     = bytes_q;
        mem_en_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        pf_fill_d   = pf_fill_q;
        unique case (state_q)
            StIdle: begin
                if (!flush_i && (miss || pf_start)) begin
                    fill_addr_d = miss ? req_tag : pf_target;
                    pf_fill_d   = !miss;
                    k_d         = '0;
                    mem_en_d    = 1'b1;
                    mem_addr_d  = fill_addr_d;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                case (k_q)
                    2'd1:    bytes_d[7:0]   = mem_rdata_i;
                    2'd2:    bytes_d[15:8]  = mem_rdata_i;
                    2'd3:    bytes_d[23:16] = mem_rdata_i;
                    default: ;
                endcase
                if (k_q == KLast) begin
                    state_d = StDrain;
                end else begin
                    k_d        = k_q + 2'd1;
                    mem_en_d   = 1'b1;
                    mem_addr_d = next_addr;
                end
            end
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d   = StIdle;
            k_d       = '0;
            bytes_d   = '0;
            mem_en_d  = 1'b0;
            pf_fill_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            k_q         <= '0;
            fill_addr_q <= '0;
            bytes_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            pf_fill_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            fill_addr_q <= fill_addr_d;
            bytes_q     <= bytes_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            pf_fill_q   <= pf_fill_d;
        end
    end

    always_comb begin
        core_ins_o   = NOP_INS;
        core_valid_o = 1'b0;
        if (core_ce_i) begin
            if (dem_hit) begin
                core_ins_o   = dem_data;
                core_valid_o = 1'b1;
            end else if (pf_hit) begin
                core_ins_o   = pf_data;
                core_valid_o = 1'b1;
            end else if (fwd_hit) begin
                core_ins_o   = drain_word;
                core_valid_o = 1'b1;
            end
        end
    end

    assign core_stall_o = miss;
    assign mem_en_o     = mem_en_q;
    assign mem_addr_o   = mem_addr_q;

endmodule
